// File: rtl/ram_stream_reader.sv
// ram_stream_reader
// Streams a contiguous, wrapping address range out of a two-cycle-latency
// block RAM onto a valid/ready interface. A small credit scheme (FIFO
// occupancy plus reads still in flight) throttles read issue so the output
// FIFO can never overflow, which gives full backpressure support while still
// sustaining one word per cycle when the consumer is always ready.
module ram_stream_reader #(
   parameter int DATA_WIDTH       = 8,
   parameter int ADDR_WIDTH       = 12,
   parameter int FIFO_DEPTH_WIDTH = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic [ADDR_WIDTH:0]   length,
   output logic [ADDR_WIDTH-1:0] ram_read_addr,
   input  logic [DATA_WIDTH-1:0] ram_data_in,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  done
);

   localparam int DEPTH    = 1 << FIFO_DEPTH_WIDTH;
   // FIFO count must represent 0..DEPTH inclusive.
   localparam int CNT_W    = FIFO_DEPTH_WIDTH + 1;
   // Credit sum is count (up to DEPTH) plus up to two in-flight reads.
   localparam int CREDIT_W = FIFO_DEPTH_WIDTH + 2;

   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH:0]   REM_ONE  = (ADDR_WIDTH + 1)'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t                  state_reg;
   state_t                  state_next;
   logic [ADDR_WIDTH-1:0]   addr_reg;
   logic [ADDR_WIDTH:0]     remaining_reg;
   // Bit 0: read issued last cycle (RAM is latching the address).
   // Bit 1: RAM data for that read is on ram_data_in this cycle.
   logic [1:0]              inflight_reg;
   logic [CNT_W-1:0]        fifo_count_reg;
   logic [CNT_W-1:0]        fifo_count_next;
   logic [CNT_W-1:0]        fifo_wr_idx;
   logic [DATA_WIDTH-1:0]   fifo_mem_reg [DEPTH];
   logic [DATA_WIDTH-1:0]   fifo_mem_next [DEPTH];
   logic [CREDIT_W-1:0]     credit_used;
   logic                    done_reg;
   logic                    done_next;
   logic                    load_cmd;
   logic                    issue;
   logic                    fifo_push;
   logic                    fifo_pop;

   // Stage-2 of the in-flight pipe qualifies the RAM output for a FIFO write.
   assign fifo_push = inflight_reg[1];
   assign fifo_pop  = out_valid && out_ready;

   // Every word that will eventually land in the FIFO holds a credit from
   // the moment its read is issued, so the FIFO cannot be overrun.
   assign credit_used = CREDIT_W'(fifo_count_reg)
                      + CREDIT_W'(inflight_reg[0])
                      + CREDIT_W'(inflight_reg[1]);

   assign issue = (state_reg == S_READ)
               && (remaining_reg != '0)
               && (credit_used < CREDIT_W'(DEPTH));

   assign fifo_count_next = fifo_count_reg + CNT_W'(fifo_push) - CNT_W'(fifo_pop);

   // The FIFO shifts toward entry 0 on a pop, so an incoming word lands one
   // slot lower when a pop happens in the same cycle.
   assign fifo_wr_idx = fifo_count_reg - CNT_W'(fifo_pop);

   // Next-state and command-control decode.
   always_comb begin
      state_next = state_reg;
      load_cmd   = 1'b0;
      done_next  = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (start) begin
               load_cmd   = 1'b1;
               state_next = (length == '0) ? S_DRAIN : S_READ;
            end
         end
         S_READ: begin
            if ((remaining_reg == '0) || (issue && (remaining_reg == REM_ONE))) begin
               state_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // Leave as soon as this cycle's pop empties everything, so that
            // done lands in the cycle right after the final handshake.
            if ((inflight_reg == 2'b00) && (fifo_count_next == '0)) begin
               state_next = S_IDLE;
               done_next  = 1'b1;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // State register and the one-cycle done pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= S_IDLE;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         done_reg  <= done_next;
      end
   end

   // Read address and remaining-word counter; address wraps naturally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_reg      <= '0;
         remaining_reg <= '0;
      end else if (load_cmd) begin
         addr_reg      <= start_addr;
         remaining_reg <= length;
      end else if (issue) begin
         addr_reg      <= addr_reg + ADDR_ONE;
         remaining_reg <= remaining_reg - REM_ONE;
      end
   end

   // In-flight valid pipe tracking the RAM's two-cycle read latency.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inflight_reg <= 2'b00;
      end else begin
         inflight_reg <= {inflight_reg[0], issue};
      end
   end

   // Per-entry next value: shift down on pop, capture RAM data at the
   // current tail slot on push, otherwise hold.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_fifo_entry
         logic [DATA_WIDTH-1:0] shifted;
         if (gi < DEPTH - 1) begin : g_mid
            assign shifted = fifo_pop ? fifo_mem_reg[gi + 1] : fifo_mem_reg[gi];
         end else begin : g_last
            assign shifted = fifo_mem_reg[gi];
         end
         assign fifo_mem_next[gi] = (fifo_push && (fifo_wr_idx == CNT_W'(gi)))
                                  ? ram_data_in : shifted;
      end
   endgenerate

   // FIFO storage; entry 0 is the head and drives out_data directly.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            fifo_mem_reg[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            fifo_mem_reg[i] <= fifo_mem_next[i];
         end
      end
   end

   // FIFO occupancy counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fifo_count_reg <= '0;
      end else begin
         fifo_count_reg <= fifo_count_next;
      end
   end

   assign ram_read_addr = addr_reg;
   assign out_data      = fifo_mem_reg[0];
   assign out_valid     = (fifo_count_reg != '0);
   assign busy          = (state_reg == S_READ) || (state_reg == S_DRAIN);
   assign done          = done_reg;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader: a behavioural two-cycle-latency RAM
// holding mem[i] = i[7:0], and a sequence of commands covering a plain burst,
// wrap-around, random backpressure, a long stall, zero length, start while
// busy, a full-space read and a reset in mid-transfer.
module tb_ram_stream_reader;

   logic        clk;
   logic        reset;
   logic        start;
   logic [11:0] start_addr;
   logic [12:0] length;
   logic [11:0] ram_read_addr;
   logic [7:0]  ram_data_in;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   ram_stream_reader #(
      .DATA_WIDTH       (8),
      .ADDR_WIDTH       (12),
      .FIFO_DEPTH_WIDTH (2)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .start_addr    (start_addr),
      .length        (length),
      .ram_read_addr (ram_read_addr),
      .ram_data_in   (ram_data_in),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .busy          (busy),
      .done          (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural RAM: registered address, then registered data.
   logic [7:0]  mem [4096];
   logic [11:0] ram_addr_q;
   logic [7:0]  ram_data_q;
   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 8'(i);
   end
   always @(posedge clk) begin
      ram_addr_q <= ram_read_addr;
      ram_data_q <= mem[ram_addr_q];
   end
   assign ram_data_in = ram_data_q;

   // A push into a full FIFO without a simultaneous pop is a design error.
   always @(negedge clk) begin
      if (!reset) begin
         assert (!(dut.fifo_push && !dut.fifo_pop && (dut.fifo_count_reg == 3'd4))) else begin
            errors++;
            $error("FAIL fifo_overflow observed=push_into_full required=no_push_into_full");
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one command and consume its stream.
   //   mode 0: out_ready high, mode 1: out_ready random 50%
   //   stall : out_ready held low for cycles 0..stall-1 after start
   //   inject: pulse a conflicting start in cycle 5 (must be ignored)
   task automatic run_cmd(input string name, input logic [11:0] sa, input logic [12:0] len,
                          input int mode, input int stall, input bit inject);
      int          k;
      int          cyc;
      int          first_hs;
      int          last_hs;
      int          budget;
      int          exp_done_cyc;
      bit          prev_stall;
      bit          seen_done;
      bit          any_valid;
      logic [7:0]  prev_data;
      logic [7:0]  expw;
      logic [11:0] sa4;
      k = 0; cyc = 0; first_hs = -1; last_hs = -1;
      prev_stall = 1'b0; seen_done = 1'b0; any_valid = 1'b0; prev_data = '0;
      budget = (int'(len) + 8) * 6 + 40;
      @(negedge clk);
      start      = 1'b1;
      start_addr = sa;
      length     = len;
      out_ready  = (stall > 0) ? 1'b0 : 1'b1;
      while ((cyc < budget) && !seen_done) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         if (inject && (cyc == 5)) begin
            start      = 1'b1;
            start_addr = sa + 12'h155;
            length     = 13'd3;
         end
         if (cyc == 1) begin
            chk({name, "_busy_c1"}, 32'(busy), 32'd1);
            chk({name, "_addr_c1"}, 32'(ram_read_addr), 32'(sa));
         end
         if ((stall > 0) && (cyc == stall)) begin
            sa4 = sa + 12'd4;
            chk({name, "_stall_addr"}, 32'(ram_read_addr), 32'(sa4));
            chk({name, "_stall_valid"}, 32'(out_valid), 32'd1);
            chk({name, "_stall_head"}, 32'(out_data), 32'(sa[7:0]));
         end
         if (done) begin
            seen_done    = 1'b1;
            exp_done_cyc = (len == 13'd0) ? 2 : last_hs + 1;
            chk({name, "_done_cycle"}, 32'(cyc), 32'(exp_done_cyc));
            chk({name, "_busy_at_done"}, 32'(busy), 32'd0);
         end else begin
            if (prev_stall) begin
               chk({name, "_hold_valid"}, 32'(out_valid), 32'd1);
               chk({name, "_hold_data"}, 32'(out_data), 32'(prev_data));
            end
            if (cyc < stall) out_ready = 1'b0;
            else if (mode == 1) out_ready = 1'($urandom_range(0, 1));
            else out_ready = 1'b1;
            if (out_valid) any_valid = 1'b1;
            if (out_valid && out_ready) begin
               expw = 8'(sa + k[11:0]);
               chk({name, "_data"}, 32'(out_data), 32'(expw));
               if (first_hs < 0) first_hs = cyc;
               last_hs = cyc;
               k++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
         end
      end
      chk({name, "_done_seen"}, 32'(seen_done), 32'd1);
      chk({name, "_word_count"}, 32'(k), 32'(len));
      if (len == 13'd0) chk({name, "_no_valid"}, 32'(any_valid), 32'd0);
      if ((mode == 0) && (stall == 0) && (len != 13'd0)) begin
         chk({name, "_first_valid_cycle"}, 32'(first_hs), 32'd4);
         chk({name, "_last_valid_cycle"}, 32'(last_hs), 32'(3 + int'(len)));
      end
      $display("cmd %s start_addr=%03h length=%0d words=%0d cycles=%0d", name, sa, len, k, cyc);
   endtask

   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      start_addr = '0;
      length     = '0;
      out_ready  = 1'b1;

      // Reset state.
      repeat (2) @(negedge clk);
      chk("rst_addr", 32'(ram_read_addr), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Plain 8-word burst: 0x10..0x17 on cycles 4..11, done in cycle 12.
      run_cmd("burst8", 12'h010, 13'd8, 0, 0, 1'b0);
      // Wrap from the top of the address space.
      run_cmd("wrap", 12'hFFE, 13'd4, 0, 0, 1'b0);
      // Random backpressure, with an ignored start while busy.
      run_cmd("backpressure", 12'h040, 13'd16, 1, 0, 1'b1);
      // Consumer stalled for 20 cycles after start.
      run_cmd("stall", 12'h123, 13'd8, 0, 20, 1'b0);
      // Zero-length command.
      run_cmd("len0", 12'h0AB, 13'd0, 0, 0, 1'b0);
      // Every address once, ending with the address back at its start.
      run_cmd("full_space", 12'h7A5, 13'd4096, 0, 0, 1'b0);
      chk("full_space_addr_wrapped", 32'(ram_read_addr), 32'h7A5);

      // Reset in the middle of a 16-word transfer.
      @(negedge clk);
      start      = 1'b1;
      start_addr = 12'h200;
      length     = 13'd16;
      out_ready  = 1'b1;
      repeat (7) begin
         @(negedge clk);
         start = 1'b0;
      end
      chk("midrst_was_streaming", 32'(out_valid), 32'd1);
      reset = 1'b1;
      #1;
      chk("midrst_addr", 32'(ram_read_addr), 32'd0);
      chk("midrst_out_data", 32'(out_data), 32'd0);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk("postrst_done", 32'(done), 32'd0);
         chk("postrst_valid", 32'(out_valid), 32'd0);
      end
      $display("cmd midreset start_addr=200 length=16 aborted");
      // Fresh command must stream clean data with no stale words.
      run_cmd("after_reset", 12'h300, 13'd5, 0, 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
